ctxt_writer: RTL and testbench

//  Host-side writer for the text-mode screen RAM scanned by the character display path.

---
 rtl/ctxt_wr_if.sv | 11 +
 rtl/ctxt_writer.sv | 147 ++++++++++++++
 tb/tb_ctxt_writer.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/ctxt_wr_if.sv
// ctxt_wr_if: host byte stream and screen RAM write port of ctxt_writer
interface ctxt_wr_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    modport master (output in_data, in_valid, input in_ready, wr_addr, wr_data, wr_en);
    modport slave  (input in_data, in_valid, output in_ready, wr_addr, wr_data, wr_en);
endinterface

// File: rtl/ctxt_writer.sv
// ctxt_writer: text screen RAM writer with cursor, control codes and row blanking; CTXT_WR_ATTR_ESC_EN enables ESC attribute load
module ctxt_writer #(
    parameter int         COLS         = 80,
    parameter int         ROWS         = 30,
    parameter logic [7:0] DEFAULT_ATTR = 8'h07
) (
    input  logic       clk,
    input  logic       rst,
    ctxt_wr_if.slave   bus,
    output logic [6:0] cur_col,
    output logic [4:0] cur_row,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, WR_CHR, WR_ATTR, CLR_ROW, CLR_SCR} state_t;
    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);
    state_t      state, state_n;
    logic [6:0]  col_n;
    logic [4:0]  row_n, row_adv;
    logic [15:0] addr_n;
    logic [7:0]  data_n, attr;
    logic        en_n, accept;
    logic [6:0]  sw_col;
    logic [4:0]  sw_row;
    logic        sw_sel;
    assign accept  = bus.in_valid & bus.in_ready;
    assign row_adv = cur_row == LAST_ROW ? 5'd0 : cur_row + 5'd1;
    // The sweep position of a clear is the address register itself
    assign sw_sel = bus.wr_addr[0];
    assign sw_col = bus.wr_addr[7:1];
    assign sw_row = bus.wr_addr[12:8];
`ifdef CTXT_WR_ATTR_ESC_EN
    logic [7:0] attr_n;
    logic       esc, esc_n;
    always_ff @(posedge clk) begin
        if (rst) begin
            attr <= DEFAULT_ATTR;
            esc  <= 1'b0;
        end else begin
            attr <= attr_n;
            esc  <= esc_n;
        end
    end
`else
    assign attr = DEFAULT_ATTR;
`endif
    always_comb begin
        state_n = state;
        col_n   = cur_col;
        row_n   = cur_row;
        addr_n  = bus.wr_addr;
        data_n  = bus.wr_data;
        en_n    = 1'b0;
`ifdef CTXT_WR_ATTR_ESC_EN
        attr_n  = attr;
        esc_n   = esc;
`endif
        unique case (state)
            IDLE: if (accept) begin
`ifdef CTXT_WR_ATTR_ESC_EN
                if (esc) begin
                    attr_n = bus.in_data;
                    esc_n  = 1'b0;
                end else if (bus.in_data == 8'h1B) esc_n = 1'b1;
                else
`endif
                if (bus.in_data inside {[8'h20:8'h7E]}) begin
                    state_n = WR_CHR;
                    en_n    = 1'b1;
                    addr_n  = {3'b0, cur_row, cur_col, 1'b0};
                    data_n  = bus.in_data;
                end else if (bus.in_data == 8'h0D) col_n = 7'd0;
                else if (bus.in_data == 8'h0A) begin
                    col_n   = 7'd0;
                    row_n   = row_adv;
                    state_n = CLR_ROW;
                    en_n    = 1'b1;
                    addr_n  = {3'b0, row_adv, 7'd0, 1'b0};
                    data_n  = 8'h20;
                end else if (bus.in_data == 8'h08) col_n = cur_col != 7'd0 ? cur_col - 7'd1 : cur_col;
                else if (bus.in_data == 8'h0C) begin
                    state_n = CLR_SCR;
                    en_n    = 1'b1;
                    addr_n  = 16'd0;
                    data_n  = 8'h20;
                end
            end
            WR_CHR: begin
                state_n   = WR_ATTR;
                en_n      = 1'b1;
                addr_n[0] = 1'b1;
                data_n    = attr;
            end
            WR_ATTR: if (cur_col == LAST_COL) begin
                col_n   = 7'd0;
                row_n   = row_adv;
                state_n = CLR_ROW;
                en_n    = 1'b1;
                addr_n  = {3'b0, row_adv, 7'd0, 1'b0};
                data_n  = 8'h20;
            end else begin
                col_n   = cur_col + 7'd1;
                state_n = IDLE;
            end
            CLR_ROW, CLR_SCR: begin
                en_n = 1'b1;
                if (!sw_sel) begin
                    addr_n[0] = 1'b1;
                    data_n    = attr;
                end else if (sw_col != LAST_COL) begin
                    addr_n = {3'b0, sw_row, sw_col + 7'd1, 1'b0};
                    data_n = 8'h20;
                end else if (state == CLR_SCR && sw_row != LAST_ROW) begin
                    addr_n = {3'b0, sw_row + 5'd1, 7'd0, 1'b0};
                    data_n = 8'h20;
                end else begin
                    en_n    = 1'b0;
                    state_n = IDLE;
                    col_n   = state == CLR_SCR ? 7'd0 : cur_col;
                    row_n   = state == CLR_SCR ? 5'd0 : cur_row;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur_col      <= 7'd0;
            cur_row      <= 5'd0;
            bus.wr_addr  <= 16'd0;
            bus.wr_data  <= 8'd0;
            bus.wr_en    <= 1'b0;
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            cur_col      <= col_n;
            cur_row      <= row_n;
            bus.wr_addr  <= addr_n;
            bus.wr_data  <= data_n;
            bus.wr_en    <= en_n;
            bus.in_ready <= state_n == IDLE;
            busy         <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_ctxt_writer.sv
// tb_ctxt_writer: directed and random bytes against a cell-level screen model of ctxt_writer
module tb_ctxt_writer;
    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam logic [7:0] DEF_ATTR = 8'h07;
`ifdef CTXT_WR_ATTR_ESC_EN
    localparam bit ESC_EN = 1'b1;
`else
    localparam bit ESC_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] cur_col;
    logic [4:0] cur_row;
    logic       busy;
    ctxt_wr_if bus ();
    ctxt_writer #(.COLS(COLS), .ROWS(ROWS), .DEFAULT_ATTR(DEF_ATTR)) dut (
        .clk(clk), .rst(rst), .bus(bus), .cur_col(cur_col), .cur_row(cur_row), .busy(busy)
    );
    always #5 clk = ~clk;
    int checks = 0;
    int failures = 0;
    int m_col, m_row;
    logic [7:0] m_attr;
    bit m_esc;
    logic [23:0] exp_q[$];
    logic [23:0] e_w;
    logic [15:0] last_addr;
    logic [7:0]  last_data;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask
    task automatic put(input int r, input int c, input int s, input logic [7:0] d);
        exp_q.push_back({16'(r * 256 + c * 2 + s), d});
    endtask
    task automatic blank_row(input int r);
        for (int c = 0; c < COLS; c++) begin
            put(r, c, 0, 8'h20);
            put(r, c, 1, m_attr);
        end
    endtask
    task automatic newline();
        m_row = (m_row + 1) % ROWS;
        blank_row(m_row);
    endtask
    task automatic model(input logic [7:0] b);
        if (m_esc) begin
            m_attr = b;
            m_esc  = 1'b0;
        end else if (ESC_EN && b == 8'h1B) m_esc = 1'b1;
        else if (b >= 8'h20 && b <= 8'h7E) begin
            put(m_row, m_col, 0, b);
            put(m_row, m_col, 1, m_attr);
            if (m_col == COLS - 1) begin
                m_col = 0;
                newline();
            end else m_col++;
        end else if (b == 8'h0D) m_col = 0;
        else if (b == 8'h0A) begin
            m_col = 0;
            newline();
        end else if (b == 8'h08) begin
            if (m_col > 0) m_col--;
        end else if (b == 8'h0C) begin
            for (int r = 0; r < ROWS; r++) blank_row(r);
            m_col = 0;
            m_row = 0;
        end
    endtask
    task automatic model_reset();
        m_col = 0;
        m_row = 0;
        m_attr = DEF_ATTR;
        m_esc = 1'b0;
        exp_q.delete();
    endtask
    always @(negedge clk) begin
        if (!rst && bus.wr_en) begin
            chk("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e_w = exp_q.pop_front();
                chk("wr_addr", 32'(bus.wr_addr), 32'(e_w[23:8]));
                chk("wr_data", 32'(bus.wr_data), 32'(e_w[7:0]));
            end
            last_addr = bus.wr_addr;
            last_data = bus.wr_data;
        end
    end
    task automatic send(input logic [7:0] b, output int busy_cnt, output int cyc);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 6000) begin
            @(negedge clk);
            n++;
        end
        bus.in_data = b;
        bus.in_valid = 1'b1;
        model(b);
        @(negedge clk);
        bus.in_valid = 1'b0;
        cyc = 1;
        busy_cnt = 0;
        while (!bus.in_ready && cyc < 6000) begin
            busy_cnt += int'(busy);
            @(negedge clk);
            cyc++;
        end
        chk("ready_back", 32'(bus.in_ready), 32'd1);
        chk("cursor", {20'd0, cur_row, cur_col}, {20'd0, 5'(m_row), 7'(m_col)});
        chk("writes_left", 32'(exp_q.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask
    task automatic send_n(input logic [7:0] b, input int count);
        int bc, cy;
        for (int i = 0; i < count; i++) send(b, bc, cy);
    endtask
    task automatic send_print(input int count);
        int bc, cy;
        for (int i = 0; i < count; i++) send(8'($urandom_range(32, 126)), bc, cy);
    endtask
    initial begin
        int bc, cy, sel;
        logic [7:0] b;
        bus.in_data = 8'h00;
        bus.in_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cursor", {20'd0, cur_row, cur_col}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_rst", 32'(bus.in_ready), 32'd1);
        send(8'h41, bc, cy);
        chk("a_cur_col", 32'(cur_col), 32'd1);
        chk("a_ready_latency", 32'(cy), 32'd3);
        chk("a_busy_cycles", 32'(bc), 32'd2);
        chk("a_last_addr", 32'(last_addr), 32'h0001);
        send(8'h0D, bc, cy);
        chk("cr_busy", 32'(bc), 32'd0);
        send_n(8'h0A, 5);
        send_print(79);
        chk("pre_z_cursor", {20'd0, cur_row, cur_col}, {20'd0, 5'd5, 7'd79});
        send(8'h5A, bc, cy);
        chk("z_cursor", {20'd0, cur_row, cur_col}, {20'd0, 5'd6, 7'd0});
        chk("z_busy", 32'(bc), 32'd162);
        chk("z_last_addr", 32'(last_addr), 32'h069F);
        send_n(8'h0A, 23);
        send_print(10);
        chk("pre_lf_cursor", {20'd0, cur_row, cur_col}, {20'd0, 5'd29, 7'd10});
        send(8'h0A, bc, cy);
        chk("lf_wrap_cursor", {20'd0, cur_row, cur_col}, 32'd0);
        chk("lf_busy", 32'(bc), 32'd160);
        chk("lf_last_addr", 32'(last_addr), 32'h009F);
        send(8'h0C, bc, cy);
        chk("ff_busy", 32'(bc), 32'd4800);
        chk("ff_last_addr", 32'(last_addr), 32'h1D9F);
        chk("ff_cursor", {20'd0, cur_row, cur_col}, 32'd0);
        send(8'h08, bc, cy);
        chk("bs_col0_cursor", {20'd0, cur_row, cur_col}, 32'd0);
        send(8'h1B, bc, cy);
        send(8'h9C, bc, cy);
        send(8'h78, bc, cy);
        chk("esc_char_attr", 32'(last_data), ESC_EN ? 32'h9C : 32'h07);
        chk("esc_char_addr", 32'(last_addr), 32'h0001);
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 9));
            b = sel < 6 ? 8'($urandom_range(32, 126)) :
                sel == 6 ? 8'h0D : sel == 7 ? 8'h08 : sel == 8 ? 8'h0A : 8'($urandom_range(0, 255));
            if (b == 8'h0C) b = 8'h0D;
            send(b, bc, cy);
        end
        @(negedge clk);
        bus.in_data = 8'h0C;
        bus.in_valid = 1'b1;
        model(8'h0C);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (1000) @(negedge clk);
        chk("mid_clear_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("abort_wr_en", 32'(bus.wr_en), 32'd0);
        chk("abort_cursor", {20'd0, cur_row, cur_col}, 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_ready_back", 32'(bus.in_ready), 32'd1);
        chk("abort_no_write", 32'(bus.wr_en), 32'd0);
        send(8'h41, bc, cy);
        chk("post_abort_addr", 32'(last_addr), 32'h0001);
        chk("post_abort_attr", 32'(last_data), 32'h07);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
